// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
//   Shared definitions for the ID/EX stage:
//   - ALU operation encodings (ALU_*), width ALU_OPW
//   - forwarding-select encodings (FWD_REG / FWD_MEM / FWD_WB)
//   - packed control bundle carried through the ID/EX register
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

  localparam int ALU_OPW = 4;

  localparam logic [ALU_OPW-1:0] ALU_NOP  = 4'h0;
  localparam logic [ALU_OPW-1:0] ALU_ADD  = 4'h1;
  localparam logic [ALU_OPW-1:0] ALU_SUB  = 4'h2;
  localparam logic [ALU_OPW-1:0] ALU_AND  = 4'h3;
  localparam logic [ALU_OPW-1:0] ALU_OR   = 4'h4;
  localparam logic [ALU_OPW-1:0] ALU_XOR  = 4'h5;
  localparam logic [ALU_OPW-1:0] ALU_NOR  = 4'h6;
  localparam logic [ALU_OPW-1:0] ALU_SLL  = 4'h7;
  localparam logic [ALU_OPW-1:0] ALU_SRL  = 4'h8;
  localparam logic [ALU_OPW-1:0] ALU_SRA  = 4'h9;
  localparam logic [ALU_OPW-1:0] ALU_SLT  = 4'hA;
  localparam logic [ALU_OPW-1:0] ALU_SLTU = 4'hB;
  localparam logic [ALU_OPW-1:0] ALU_LUI  = 4'hC;

  // Where an operand comes from.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,  // latched regfile data
    FWD_MEM = 2'b01,  // EX/MEM ALU result
    FWD_WB  = 2'b10   // MEM/WB write data
  } fwd_sel_t;

  // Control that must be cleared by a bubble or a flush.
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
    logic memwrite;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// id_ex_stage_fwd_mux
//   Operand forwarding select and data mux for one source register.
//   The EX/MEM result takes precedence over MEM/WB; register 0 is never
//   forwarded and always yields the latched regfile data.
// Ports
//   idx           in  RW  registered source index
//   reg_data      in  DW  latched regfile data for idx
//   mem_regwrite  in  1   EX/MEM writes a register
//   mem_rd        in  RW  EX/MEM destination
//   mem_result    in  DW  EX/MEM ALU result
//   wb_regwrite   in  1   MEM/WB writes a register
//   wb_rd         in  RW  MEM/WB destination
//   wb_result     in  DW  MEM/WB write data
//   data          out DW  selected operand
//   sel           out 2   which source was selected (fwd_sel_t)
// ---------------------------------------------------------------------------
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] reg_data,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_result,
  output logic [DW-1:0] data,
  output fwd_sel_t      sel
);

  logic idx_nz;
  logic mem_hit;
  logic wb_hit;

  assign idx_nz  = (idx != '0);
  assign mem_hit = mem_regwrite && (mem_rd == idx) && idx_nz;
  assign wb_hit  = wb_regwrite  && (wb_rd  == idx) && idx_nz;

  // The younger producer (EX/MEM) holds the newer value, so it wins.
  always_comb begin
    sel = FWD_REG;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    data = reg_data;
    case (sel)
      FWD_MEM: data = mem_result;
      FWD_WB:  data = wb_result;
      default: data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register and ALU operand selection.
//   Latches decoded operands and control from ID, forwards EX/MEM and MEM/WB
//   results onto the ALU operands, detects load-use hazards (stalling ID and
//   inserting one bubble) and counts inserted bubbles with saturation.
//
//   Per-edge priority: rst > flush > ex_stall > load-use bubble > capture.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs, id_rt, id_rd      source / destination register indices
//   id_rs_data, id_rt_data   regfile read data
//   id_imm, id_shamt         extended immediate, shift amount
//   id_aluop, id_alusrc      ALU operation, B-source select (1: imm)
//   id_regwrite/memread/memwrite   decoded control
//   ex_stall                 downstream hold; freeze this stage
//   flush                    kill the instruction entering EX
//   mem_regwrite/rd/result   EX/MEM forwarding source
//   wb_regwrite/rd/result    MEM/WB forwarding source
//   id_stall                 combinational load-use stall to ID/IF
//   alu_a, alu_b, alu_op, alu_shamt   ALU inputs
//   ex_valid, ex_rd, ex_regwrite, ex_memread, ex_memwrite   EX control
//   ex_store_data            forwarded rt value for stores
//   bubble_cnt               saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int OPW = 4,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [RW-1:0]  id_rs,
  input  logic [RW-1:0]  id_rt,
  input  logic [RW-1:0]  id_rd,
  input  logic [DW-1:0]  id_rs_data,
  input  logic [DW-1:0]  id_rt_data,
  input  logic [DW-1:0]  id_imm,
  input  logic [4:0]     id_shamt,
  input  logic [OPW-1:0] id_aluop,
  input  logic           id_alusrc,
  input  logic           id_regwrite,
  input  logic           id_memread,
  input  logic           id_memwrite,
  input  logic           ex_stall,
  input  logic           flush,
  input  logic           mem_regwrite,
  input  logic [RW-1:0]  mem_rd,
  input  logic [DW-1:0]  mem_result,
  input  logic           wb_regwrite,
  input  logic [RW-1:0]  wb_rd,
  input  logic [DW-1:0]  wb_result,
  output logic           id_stall,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  output logic [4:0]     alu_shamt,
  output logic           ex_valid,
  output logic [RW-1:0]  ex_rd,
  output logic           ex_regwrite,
  output logic           ex_memread,
  output logic           ex_memwrite,
  output logic [DW-1:0]  ex_store_data,
  output logic [CW-1:0]  bubble_cnt
);

  localparam logic [OPW-1:0] OP_NOP = OPW'(ALU_NOP);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // ID/EX register contents
  ex_ctrl_t       ctrl_p1;
  logic [OPW-1:0] aluop_p1;
  logic           alusrc_p1;
  logic [RW-1:0]  rs_p1;
  logic [RW-1:0]  rt_p1;
  logic [RW-1:0]  rd_p1;
  logic [DW-1:0]  rs_data_p1;
  logic [DW-1:0]  rt_data_p1;
  logic [DW-1:0]  imm_p1;
  logic [4:0]     shamt_p1;
  logic [CW-1:0]  bubble_cnt_p1;

  logic           load_use;
  logic [DW-1:0]  fwd_rs;
  logic [DW-1:0]  fwd_rt;
  fwd_sel_t       fwd_sel_rs;
  fwd_sel_t       fwd_sel_rt;
  logic           unused_fwd_sel;

  // ---- ID side: hazard detection on the instruction currently in EX ----
  // A load in EX cannot forward its data yet; an ID consumer of that register
  // must wait one cycle. rt only counts when it actually feeds operand B or
  // the store path, i.e. when B is not the immediate.
  assign load_use = ctrl_p1.valid && ctrl_p1.memread && (rd_p1 != '0) && id_valid &&
                    ((rd_p1 == id_rs) || ((rd_p1 == id_rt) && !id_alusrc));

  // A flush discards the ID instruction anyway, so no stall is needed.
  assign id_stall = load_use && !flush;

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_p1       <= CTRL_NONE;
      aluop_p1      <= OP_NOP;
      alusrc_p1     <= 1'b0;
      rs_p1         <= '0;
      rt_p1         <= '0;
      rd_p1         <= '0;
      rs_data_p1    <= '0;
      rt_data_p1    <= '0;
      imm_p1        <= '0;
      shamt_p1      <= '0;
      bubble_cnt_p1 <= '0;
    end else if (flush) begin
      ctrl_p1  <= CTRL_NONE;
      aluop_p1 <= OP_NOP;
    end else if (!ex_stall) begin
      if (load_use) begin
        ctrl_p1       <= CTRL_NONE;
        aluop_p1      <= OP_NOP;
        bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
      end else begin
        // Data always captured; control only when ID has a real instruction.
        alusrc_p1  <= id_alusrc;
        rs_p1      <= id_rs;
        rt_p1      <= id_rt;
        rd_p1      <= id_rd;
        rs_data_p1 <= id_rs_data;
        rt_data_p1 <= id_rt_data;
        imm_p1     <= id_imm;
        shamt_p1   <= id_shamt;
        if (id_valid) begin
          ctrl_p1.valid    <= 1'b1;
          ctrl_p1.regwrite <= id_regwrite;
          ctrl_p1.memread  <= id_memread;
          ctrl_p1.memwrite <= id_memwrite;
          aluop_p1         <= id_aluop;
        end else begin
          ctrl_p1  <= CTRL_NONE;
          aluop_p1 <= OP_NOP;
        end
      end
    end
  end

  // ---- EX side: operand forwarding into the ALU ----
  id_ex_stage_fwd_mux #(
    .DW (DW),
    .RW (RW)
  ) u_fwd_rs (
    .idx          (rs_p1),
    .reg_data     (rs_data_p1),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .data         (fwd_rs),
    .sel          (fwd_sel_rs)
  );

  id_ex_stage_fwd_mux #(
    .DW (DW),
    .RW (RW)
  ) u_fwd_rt (
    .idx          (rt_p1),
    .reg_data     (rt_data_p1),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .data         (fwd_rt),
    .sel          (fwd_sel_rt)
  );

  // Select codes are informational here; the data outputs already reflect them.
  assign unused_fwd_sel = ^{fwd_sel_rs, fwd_sel_rt};

  assign alu_a         = fwd_rs;
  assign alu_b         = alusrc_p1 ? imm_p1 : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_op        = aluop_p1;
  assign alu_shamt     = shamt_p1;
  assign ex_valid      = ctrl_p1.valid;
  assign ex_rd         = rd_p1;
  assign ex_regwrite   = ctrl_p1.regwrite;
  assign ex_memread    = ctrl_p1.memread;
  assign ex_memwrite   = ctrl_p1.memwrite;
  assign bubble_cnt    = bubble_cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int OPW = 4;
  localparam int CW  = 4;   // narrow counter so saturation is reachable

  logic           clk = 1'b0;
  logic           rst;
  logic           id_valid;
  logic [RW-1:0]  id_rs, id_rt, id_rd;
  logic [DW-1:0]  id_rs_data, id_rt_data, id_imm;
  logic [4:0]     id_shamt;
  logic [OPW-1:0] id_aluop;
  logic           id_alusrc, id_regwrite, id_memread, id_memwrite;
  logic           ex_stall, flush;
  logic           mem_regwrite, wb_regwrite;
  logic [RW-1:0]  mem_rd, wb_rd;
  logic [DW-1:0]  mem_result, wb_result;
  logic           id_stall;
  logic [DW-1:0]  alu_a, alu_b, ex_store_data;
  logic [OPW-1:0] alu_op;
  logic [4:0]     alu_shamt;
  logic           ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [RW-1:0]  ex_rd;
  logic [CW-1:0]  bubble_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .RW(RW), .OPW(OPW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_aluop(id_aluop), .id_alusrc(id_alusrc),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .ex_stall(ex_stall), .flush(flush),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .id_stall(id_stall), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_shamt(alu_shamt), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_store_data(ex_store_data), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                        input logic [RW-1:0] rd, input logic [DW-1:0] rsd,
                        input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
                        input logic [OPW-1:0] op, input logic src, input logic rw,
                        input logic mr, input logic mw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_aluop = op; id_alusrc = src; id_regwrite = rw; id_memread = mr; id_memwrite = mw;
  endtask

  initial begin
    rst = 1'b1; ex_stall = 1'b0; flush = 1'b0; id_shamt = 5'd7;
    mem_regwrite = 1'b0; mem_rd = '0; mem_result = '0;
    wb_regwrite = 1'b0; wb_rd = '0; wb_result = '0;
    set_id(0, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;

    // reset state
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'(ALU_NOP));
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_bubble", 32'(bubble_cnt), 32'd0);
    chk("rst_id_stall", 32'(id_stall), 32'd0);

    // plain capture, 1-cycle latency
    set_id(1, 5'd3, 5'd4, 5'd6, 32'h11, 32'h22, 32'h100, ALU_ADD, 0, 1, 0, 0);
    step();
    chk("cap_valid", 32'(ex_valid), 32'd1);
    chk("cap_alu_a", alu_a, 32'h11);
    chk("cap_alu_b", alu_b, 32'h22);
    chk("cap_alu_op", 32'(alu_op), 32'(ALU_ADD));
    chk("cap_rd", 32'(ex_rd), 32'd6);
    chk("cap_shamt", 32'(alu_shamt), 32'd7);
    chk("cap_regwrite", 32'(ex_regwrite), 32'd1);
    id_valid = 1'b0;

    // MEM beats WB on rs
    mem_regwrite = 1'b1; mem_rd = 5'd3; mem_result = 32'h55;
    wb_regwrite = 1'b1; wb_rd = 5'd3; wb_result = 32'h77;
    #1 chk("fwd_mem_over_wb", alu_a, 32'h55);
    mem_regwrite = 1'b0;
    #1 chk("fwd_wb_rs", alu_a, 32'h77);
    wb_rd = 5'd4;
    #1 chk("fwd_wb_rt_b", alu_b, 32'h77);
    chk("fwd_wb_rt_store", ex_store_data, 32'h77);
    chk("fwd_rs_none", alu_a, 32'h11);
    wb_regwrite = 1'b0; wb_rd = '0;

    // capture with id_valid=0 loads zeroed control
    set_id(0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, ALU_SUB, 0, 1, 1, 1);
    step();
    chk("inv_valid", 32'(ex_valid), 32'd0);
    chk("inv_regwrite", 32'(ex_regwrite), 32'd0);
    chk("inv_memread", 32'(ex_memread), 32'd0);
    chk("inv_memwrite", 32'(ex_memwrite), 32'd0);
    chk("inv_alu_op", 32'(alu_op), 32'(ALU_NOP));

    // register 0 never forwarded
    set_id(1, 5'd0, 5'd0, 5'd2, 32'h0, 32'h9, 32'h0, ALU_OR, 0, 1, 0, 0);
    step();
    mem_regwrite = 1'b1; mem_rd = 5'd0; mem_result = 32'hFF;
    wb_regwrite = 1'b1; wb_rd = 5'd0; wb_result = 32'hEE;
    #1 chk("r0_alu_a", alu_a, 32'h0);
    chk("r0_alu_b", alu_b, 32'h9);
    mem_regwrite = 1'b0; mem_rd = '0; wb_regwrite = 1'b0; wb_rd = '0;

    // load-use: lw $5 in EX, consumer reads rs=5
    set_id(1, 5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, 32'h4, ALU_ADD, 1, 1, 1, 0);
    step();
    chk("lw_memread", 32'(ex_memread), 32'd1);
    chk("lw_alu_a", alu_a, 32'h1000);
    chk("lw_alu_b_imm", alu_b, 32'h4);
    set_id(1, 5'd5, 5'd2, 5'd7, 32'h0, 32'h3, 32'h0, ALU_SUB, 0, 1, 0, 0);
    #1 chk("lu_id_stall", 32'(id_stall), 32'd1);
    step();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);
    chk("lu_bubble_op", 32'(alu_op), 32'(ALU_NOP));
    chk("lu_bubble_regwrite", 32'(ex_regwrite), 32'd0);
    chk("lu_bubble_memread", 32'(ex_memread), 32'd0);
    chk("lu_stall_released", 32'(id_stall), 32'd0);
    wb_regwrite = 1'b1; wb_rd = 5'd5; wb_result = 32'hAB;
    step();
    chk("lu_valid", 32'(ex_valid), 32'd1);
    chk("lu_alu_a_wb", alu_a, 32'hAB);
    chk("lu_alu_b", alu_b, 32'h3);
    chk("lu_alu_op", 32'(alu_op), 32'(ALU_SUB));
    chk("lu_rd", 32'(ex_rd), 32'd7);
    wb_regwrite = 1'b0; wb_rd = '0;

    // rt match only stalls when B is not the immediate
    set_id(1, 5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, 32'h4, ALU_ADD, 1, 1, 1, 0);
    step();
    set_id(1, 5'd1, 5'd5, 5'd9, 32'h0, 32'h0, 32'h8, ALU_ADD, 1, 1, 0, 0);
    #1 chk("lu_rt_imm_no_stall", 32'(id_stall), 32'd0);
    id_alusrc = 1'b0;
    #1 chk("lu_rt_stall", 32'(id_stall), 32'd1);

    // flush beats ex_stall and load-use
    flush = 1'b1; ex_stall = 1'b1;
    #1 chk("fl_id_stall", 32'(id_stall), 32'd0);
    step();
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_memread", 32'(ex_memread), 32'd0);
    chk("fl_bubble_cnt", 32'(bubble_cnt), 32'd1);
    flush = 1'b0; ex_stall = 1'b0;
    step();

    // ex_stall freezes the counter even with a load-use pending
    set_id(1, 5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, 32'h4, ALU_ADD, 1, 1, 1, 0);
    step();
    set_id(1, 5'd5, 5'd2, 5'd7, 32'h0, 32'h3, 32'h0, ALU_SUB, 0, 1, 0, 0);
    ex_stall = 1'b1;
    #1 chk("st_id_stall", 32'(id_stall), 32'd1);
    step();
    chk("st_bubble_frozen", 32'(bubble_cnt), 32'd1);
    chk("st_valid_held", 32'(ex_valid), 32'd1);
    chk("st_memread_held", 32'(ex_memread), 32'd1);
    ex_stall = 1'b0;
    step();
    chk("st_then_bubble", 32'(bubble_cnt), 32'd2);

    // ex_stall holds everything; alu_b stays imm despite rt forwarding
    set_id(1, 5'd2, 5'd3, 5'd8, 32'h20, 32'h30, 32'hFFFF_FFF0, ALU_OR, 1, 1, 0, 0);
    step();
    chk("hold_alu_b_cap", alu_b, 32'hFFFF_FFF0);
    mem_regwrite = 1'b1; mem_rd = 5'd3; mem_result = 32'h99;
    #1 chk("hold_alu_b_imm", alu_b, 32'hFFFF_FFF0);
    chk("hold_store_fwd", ex_store_data, 32'h99);
    ex_stall = 1'b1;
    set_id(1, 5'd9, 5'd9, 5'd9, 32'h5, 32'h6, 32'h1, ALU_AND, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_alu_b", alu_b, 32'hFFFF_FFF0);
      chk("hold_alu_a", alu_a, 32'h20);
      chk("hold_alu_op", 32'(alu_op), 32'(ALU_OR));
      chk("hold_rd", 32'(ex_rd), 32'd8);
      chk("hold_valid", 32'(ex_valid), 32'd1);
    end
    ex_stall = 1'b0; mem_regwrite = 1'b0; mem_rd = '0;

    // saturation: 13 more bubbles reach 15, one more stays at 15
    for (int i = 0; i < 14; i++) begin
      set_id(1, 5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, 32'h4, ALU_ADD, 1, 1, 1, 0);
      step();
      set_id(1, 5'd5, 5'd2, 5'd7, 32'h0, 32'h3, 32'h0, ALU_SUB, 0, 1, 0, 0);
      step();
      if (i == 12) chk("sat_reach", 32'(bubble_cnt), 32'd15);
    end
    chk("sat_no_wrap", 32'(bubble_cnt), 32'd15);

    // reset mid-stream
    set_id(1, 5'd2, 5'd3, 5'd8, 32'h20, 32'h30, 32'h40, ALU_XOR, 0, 1, 0, 0);
    step();
    chk("mid_valid_before", 32'(ex_valid), 32'd1);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(ex_valid), 32'd0);
    chk("mid_rst_op", 32'(alu_op), 32'(ALU_NOP));
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_bubble", 32'(bubble_cnt), 32'd0);
    chk("mid_rst_regwrite", 32'(ex_regwrite), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
